// File: rtl/manual_toggle_pkg.sv
// Shared types and helpers for the manual-toggle controller.
package manual_toggle_pkg;

    // Controller states; 3-bit encoding keeps the state register narrow.
    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLDOFF   = 3'd1,
        IDLE      = 3'd2,
        PRESS_DEB = 3'd3,
        PRESSED   = 3'd4,
        REL_DEB   = 3'd5
    } state_e;

    // Counter width that covers the default debounce and hold-off periods.
    localparam int DEFAULT_CNT_W = 16;

    // Smallest counter width with 2^width strictly greater than the longer period.
    function automatic int cnt_width(input int debounce_cycles, input int lock_holdoff);
        int longest;
        longest = (debounce_cycles > lock_holdoff) ? debounce_cycles : lock_holdoff;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops to settle metastability.
    // NOTE: the reset value is the input's inactive level, so a reset never
    // looks like a fresh edge to the logic downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments make both flops sample their
            // inputs together; blocking ones here would collapse them into one.
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/manual_toggle_ctrl.sv
// Debounced push-button toggle, gated by a hold-off after the PLL locks.
module manual_toggle_ctrl
    import manual_toggle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int LOCK_HOLDOFF    = 256,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    input  logic btn_n,
    output logic toggle_out,
    output logic toggle_pulse,
    output logic ready
);

    // Terminal counts: the cycle on which each period is complete.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LOCK_HOLDOFF - 1);

    logic lock_s;
    logic btn_s;
    logic pressed;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             toggle_q, toggle_d;
    logic             pulse_q, pulse_d;
    logic             ready_q, ready_d;

    // Lock flag resets low: the controller must see the PLL lock afresh.
    sync_2ff #(.RESET_VAL(1'b0)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // Button resets high (released) so reset alone never registers a press.
    sync_2ff #(.RESET_VAL(1'b1)) u_btn_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_n),
        .q     (btn_s)
    );

    assign pressed = ~btn_s;

    // Next-state, counter and output decode; lock loss overrides everything.
    always_comb begin
        // NOTE: every signal gets a default before the case statement so no
        // path leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        toggle_d = toggle_q;
        pulse_d  = 1'b0;

        if (state_q != WAIT_LOCK && !lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    cnt_d = '0;
                    if (lock_s) begin
                        state_d = HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        // A button already held here must be released first.
                        state_d = pressed ? PRESSED : IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (pressed) begin
                        cnt_d   = '0;
                        state_d = PRESS_DEB;
                    end
                end
                PRESS_DEB: begin
                    if (!pressed) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_d    = '0;
                        state_d  = PRESSED;
                        toggle_d = ~toggle_q;
                        pulse_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!pressed) begin
                        cnt_d   = '0;
                        state_d = REL_DEB;
                    end
                end
                REL_DEB: begin
                    if (pressed) begin
                        cnt_d   = '0;
                        state_d = PRESSED;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = WAIT_LOCK;
                end
            endcase
        end

        ready_d = (state_d == IDLE)    || (state_d == PRESS_DEB) ||
                  (state_d == PRESSED) || (state_d == REL_DEB);
    end

    // State, counter and registered outputs; toggle_out is held across lock loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            toggle_q <= 1'b0;
            pulse_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            toggle_q <= toggle_d;
            pulse_q  <= pulse_d;
            ready_q  <= ready_d;
        end
    end

    assign toggle_out   = toggle_q;
    assign toggle_pulse = pulse_q;
    assign ready        = ready_q;

endmodule

// File: tb/tb_manual_toggle_ctrl.sv
// Self-checking bench for manual_toggle_ctrl with a run-length reference model.
module tb_manual_toggle_ctrl;
    import manual_toggle_pkg::*;

    localparam int D = 8;
    localparam int H = 4;
    localparam int W = cnt_width(D, H);

    logic clk = 1'b0;
    logic rst_n;
    logic pll_locked;
    logic btn_n;
    logic toggle_out;
    logic toggle_pulse;
    logic ready;

    manual_toggle_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .LOCK_HOLDOFF    (H),
        .CNT_W           (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .btn_n        (btn_n),
        .toggle_out   (toggle_out),
        .toggle_pulse (toggle_pulse),
        .ready        (ready)
    );

    always #5 clk = ~clk;

    // Reference model: synchroniser pipelines, lock run length, debounced level.
    bit m_ls1, m_ls2, m_bs1, m_bs2;
    int lock_run;
    bit m_ready;
    bit m_db;
    int m_run;
    bit m_toggle;
    bit m_pulse;

    int checks = 0;
    int errors = 0;
    int pulse_seen = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ls1 = 1'b0; m_ls2 = 1'b0;
        m_bs1 = 1'b1; m_bs2 = 1'b1;
        lock_run = 0;
        m_ready  = 1'b0;
        m_db     = 1'b0;
        m_run    = 0;
        m_toggle = 1'b0;
        m_pulse  = 1'b0;
    endtask

    // Ready once the synchronised lock has been high for more than H samples;
    // a level change is accepted after D+1 consecutive disagreeing samples.
    task automatic model_edge();
        bit ls, pr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ls = m_ls2;
        pr = ~m_bs2;
        m_ls2 = m_ls1; m_ls1 = pll_locked;
        m_bs2 = m_bs1; m_bs1 = btn_n;
        m_pulse = 1'b0;
        if (!ls) begin
            lock_run = 0;
            m_ready  = 1'b0;
        end else begin
            if (lock_run <= H) lock_run++;
            if (!m_ready) begin
                if (lock_run > H) begin
                    m_ready = 1'b1;
                    m_db    = pr;
                    m_run   = 0;
                end
            end else if (pr != m_db) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_db  = pr;
                    m_run = 0;
                    if (pr) begin
                        m_toggle = ~m_toggle;
                        m_pulse  = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (toggle_pulse === 1'b1) pulse_seen++;
        check("toggle_out", toggle_out, m_toggle);
        check("toggle_pulse", toggle_pulse, m_pulse);
        check("ready", ready, m_ready);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Assert reset between clock edges and confirm outputs clear at once.
    task automatic async_reset_now(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check({tag, "_toggle"}, toggle_out, 1'b0);
        check({tag, "_pulse"}, toggle_pulse, 1'b0);
        check({tag, "_ready"}, ready, 1'b0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int p0;
        int btn_left;
        int lock_left;

        // Reset state.
        rst_n = 1'b0; pll_locked = 1'b0; btn_n = 1'b1;
        model_reset();
        #1;
        check("rst_toggle", toggle_out, 1'b0);
        check("rst_pulse", toggle_pulse, 1'b0);
        check("rst_ready", ready, 1'b0);
        ticks(3);
        rst_n = 1'b1;
        ticks(3);

        // Lock acquisition: ready exactly 6 edges after lock is first sampled.
        pll_locked = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("ready_rise", ready, (k >= 6));
            check("no_toggle_lock", toggle_out, 1'b0);
        end

        // Clean press: flip exactly 10 edges after the fall, one-cycle pulse.
        btn_n = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("press_flip", toggle_out, (k >= 10));
            check("press_pulse", toggle_pulse, (k == 10));
        end
        btn_n = 1'b1;
        ticks(20);
        btn_n = 1'b0;
        ticks(20);
        check("second_press", toggle_out, 1'b0);
        btn_n = 1'b1;
        ticks(20);

        // Bounce while released: never stable long enough to count.
        p0 = pulse_seen;
        for (int k = 0; k < 10; k++) begin
            btn_n = ~btn_n;
            ticks(3);
        end
        ticks(20);
        check("bounce_no_pulse", (pulse_seen == p0), 1'b1);
        check("bounce_hold", toggle_out, 1'b0);

        // Held press with short release glitches: one toggle only.
        p0 = pulse_seen;
        btn_n = 1'b0;
        ticks(14);
        for (int k = 0; k < 4; k++) begin
            btn_n = 1'b1; ticks(3);
            btn_n = 1'b0; ticks(5);
        end
        check("glitch_one_pulse", (pulse_seen == p0 + 1), 1'b1);
        check("glitch_toggle", toggle_out, 1'b1);
        btn_n = 1'b1;
        ticks(20);

        // Lock loss during press debounce: ready drops 2 edges later, no toggle.
        p0 = pulse_seen;
        btn_n = 1'b0;
        ticks(7);
        pll_locked = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("lockloss_ready", ready, (k < 2));
        end
        check("lockloss_hold", toggle_out, 1'b1);
        ticks(4);
        // Relock with the button still held: ready back after 6, no toggle.
        pll_locked = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("relock_ready", ready, (k >= 6));
        end
        ticks(12);
        check("relock_no_pulse", (pulse_seen == p0), 1'b1);
        btn_n = 1'b1;
        ticks(20);

        // Reach PRESSED with toggle_out=1, then reset asynchronously.
        btn_n = 1'b0; ticks(20);
        btn_n = 1'b1; ticks(20);
        btn_n = 1'b0; ticks(15);
        check("pre_reset_toggle", toggle_out, 1'b1);
        async_reset_now("async_rst");
        ticks(3);
        rst_n = 1'b1;

        // Button held through reset and lock: silent until released and re-pressed.
        p0 = pulse_seen;
        ticks(30);
        check("held_no_pulse", (pulse_seen == p0), 1'b1);
        check("held_toggle", toggle_out, 1'b0);
        btn_n = 1'b1; ticks(12);
        btn_n = 1'b0; ticks(12);
        check("held_one_pulse", (pulse_seen == p0 + 1), 1'b1);
        check("held_toggle_after", toggle_out, 1'b1);
        btn_n = 1'b1; ticks(12);

        // Randomised bouncing, lock drops and occasional resets against the model.
        btn_left = 0;
        lock_left = $urandom_range(30, 300);
        for (int i = 0; i < 3000; i++) begin
            if (btn_left == 0) begin
                btn_n = ~btn_n;
                btn_left = $urandom_range(1, 14);
            end
            btn_left--;
            if (lock_left == 0) begin
                pll_locked = ~pll_locked;
                lock_left = pll_locked ? $urandom_range(30, 300) : $urandom_range(1, 10);
            end
            lock_left--;
            if ($urandom_range(0, 999) == 0) begin
                async_reset_now("rand_rst");
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/manual_toggle_ctrl.md
Name: manual_toggle_ctrl

Overview:
- Consumes the 2 MHz PLL output clock and its locked indicator; sits directly downstream of the PLL wrapper.
- Synchronises and debounces an active-low push button, then flips a toggle output once per confirmed press.
- Ignores the button until the PLL has been locked for a hold-off period.
- Drives the board LED/enable line for the manual-toggle design.

Parameters:
- DEBOUNCE_CYCLES, 20000, consecutive stable samples needed to accept a press or release (10 ms at 2 MHz); legal range 2..65535.
- LOCK_HOLDOFF, 256, cycles that the synchronised pll_locked must stay high before ready asserts; legal range 1..65535.
- CNT_W, 16, width of the shared debounce/hold-off counter; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, LOCK_HOLDOFF).

Ports:
- clk  in  1  2 MHz PLL output clock.
- rst_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL locked flag; asynchronous to clk, synchronised internally.
- btn_n  in  1  raw push button, active-low, asynchronous and bouncy.
- toggle_out  out  1  registered toggle state.
- toggle_pulse  out  1  one-cycle strobe on the cycle toggle_out changes.
- ready  out  1  high in IDLE, PRESS_DEB, PRESSED and REL_DEB.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0, state WAIT_LOCK, counter 0.
  - Both synchronisers preset to the inactive level: lock sync 0, button sync 1 (released).
- Synchronisers:
  - pll_locked and btn_n each pass through 2 flops; lock_s and btn_s are the synchronised versions.
  - Define pressed = ~btn_s.
- FSM states, evaluated every rising clk edge:
  - WAIT_LOCK: counter 0. If lock_s=1, go to HOLDOFF.
  - HOLDOFF: counter increments each cycle. When counter = LOCK_HOLDOFF-1, clear counter and go to IDLE. ready asserts the cycle IDLE is entered.
  - IDLE: if pressed, counter 0 and go to PRESS_DEB.
  - PRESS_DEB: while pressed, counter increments. When counter = DEBOUNCE_CYCLES-1 and still pressed: go to PRESSED, toggle_out <= ~toggle_out, toggle_pulse = 1 for that one cycle. If released at any sample, return to IDLE with no toggle.
  - PRESSED: wait. If released, counter 0 and go to REL_DEB.
  - REL_DEB: while released, counter increments. When counter = DEBOUNCE_CYCLES-1, go to IDLE. If pressed again, return to PRESSED with no toggle.
- Latency: btn_n fall to toggle_out flip = 2 + DEBOUNCE_CYCLES clk edges, given a clean press.
- Lock loss: lock_s=0 in any state other than WAIT_LOCK means next state WAIT_LOCK, counter 0, ready 0, toggle_pulse 0. toggle_out is held, not cleared.
- Lock loss has priority over every press or release event in the same cycle.
- Held button: a button held through reset or lock acquisition produces no toggle until it has been released and debounced, then pressed again.
  - To achieve this, the exit from HOLDOFF goes to PRESSED instead of IDLE if pressed=1 on that cycle.
- Counter never wraps; it saturates at its terminal value only transiently, because each terminal compare causes a state exit.
- At most one toggle_pulse per full press/release cycle; no back-to-back pulses.

Decomposition:
- Package manual_toggle_pkg holds:
  - The state enum (WAIT_LOCK, HOLDOFF, IDLE, PRESS_DEB, PRESSED, REL_DEB), 3-bit encoding.
  - A default CNT_W constant.
  - A function computing the required counter width.
- Natural sub-module sync_2ff (parameter RESET_VAL), instantiated twice, for the lock and button synchronisers.
- FSM and counter stay in the top block.

Test Plan (DEBOUNCE_CYCLES=8, LOCK_HOLDOFF=4):
- Reset then pll_locked=1 at cycle 0 -> ready rises exactly at cycle 6 (2 sync + 4 hold-off); toggle_out=0 and toggle_pulse=0 throughout.
- Clean press: btn_n=0 held for 20 cycles after ready -> toggle_out 0→1 exactly 10 cycles after the fall, toggle_pulse high for 1 cycle. Release for 20 cycles, press again -> toggle_out 1→0.
- Bounce: btn_n toggles every 3 cycles for 30 cycles, then stays high -> no toggle_pulse and toggle_out unchanged. Bounce during release (press held, short 3-cycle highs) -> no extra toggle.
- Lock loss: pll_locked=0 at cycle 5 of PRESS_DEB -> ready falls 2 cycles later, no toggle, toggle_out held. Relock -> ready back 6 cycles later.
- Button held low through reset and lock -> no toggle after ready. After release for 8+ cycles and a new press for 8+ cycles -> exactly one toggle.
- Async reset mid-PRESSED with toggle_out=1 -> toggle_out, toggle_pulse and ready go to 0 immediately, without waiting for a clk edge.
